// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, fetch FSM state encoding and PC helpers.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   localparam lc3b_word PC_STEP = 16'd2;

   // Sequential PC step; 16-bit wrap from FFFE to 0000 is intentional.
   function automatic lc3b_word pc_inc(input lc3b_word pc);
      return pc + PC_STEP;
   endfunction

   // Instructions are halfword aligned, so a redirect target drops bit 0.
   function automatic lc3b_word pc_align(input lc3b_word addr);
      return {addr[15:1], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Optional fetch performance counters: words written into IF/ID and
// cycles where a live IF/ID entry is held by a downstream stall.
module fetch_perf_ctr
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetched_inc,
   input  logic        stall_inc,
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stall
);

   // Free-running wrapping event counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (fetched_inc) perf_fetched <= perf_fetched + 16'd1;
         if (stall_inc)   perf_stall   <= perf_stall + 16'd1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage with inline IF/ID register.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_FETCH   | read request for pc outstanding
// ST_HOLD    | fetched word buffered, IF/ID stalled, no request
// ST_DISCARD | request issued before a redirect; its response is dropped
module fetch_stage
   import lc3b_types::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        clk,
   input  logic        reset_n,
   output logic        mem1_read,
   output logic [15:0] mem1_address,
   input  logic        mem1_resp,
   input  logic [15:0] mem1_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        ifid_valid,
   output logic [15:0] ifid_ir,
   output logic [15:0] ifid_pc,
   output logic [3:0]  opcode,
`ifdef FETCH_PERF_EN
   output logic [11:0] IRbits,
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stall
`else
   output logic [11:0] IRbits
`endif
);

   fetch_state_e state, state_nx;
   lc3b_word     pc, pc_nx;
   lc3b_word     req_addr, req_addr_nx;
   lc3b_word     buf_ir, buf_ir_nx;
   logic         buf_valid, buf_valid_nx;
   lc3b_word     ir_nx, ifid_pc_nx;
   logic         valid_nx;
   logic         req_en;
   logic         resp_ok;
   logic         hold_ifid;

   // req_en keeps the bus quiet while in reset and for the reset-release
   // cycle; the first edge after release starts fetching from RESET_PC.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) req_en <= 1'b0;
      else          req_en <= 1'b1;
   end

   assign resp_ok   = mem1_resp & req_en;
   assign hold_ifid = stall & ifid_valid;

   // Next-state and IF/ID update; redirect outranks stall and response.
   always_comb begin
      state_nx     = state;
      pc_nx        = pc;
      req_addr_nx  = req_addr;
      buf_ir_nx    = buf_ir;
      buf_valid_nx = buf_valid;
      ir_nx        = ifid_ir;
      ifid_pc_nx   = ifid_pc;
      valid_nx     = ifid_valid;
      // An unstalled entry is consumed this cycle unless replaced below.
      if (!hold_ifid) valid_nx = 1'b0;
      case (state)
         ST_FETCH: begin
            if (redirect) begin
               pc_nx        = pc_align(redirect_pc);
               valid_nx     = 1'b0;
               buf_valid_nx = 1'b0;
               // Still waiting on the old request: remember its address.
               if (req_en && !mem1_resp) begin
                  state_nx    = ST_DISCARD;
                  req_addr_nx = pc;
               end
            end else if (resp_ok) begin
               pc_nx = pc_inc(pc);
               if (!hold_ifid) begin
                  ir_nx      = mem1_rdata;
                  ifid_pc_nx = pc_inc(pc);
                  valid_nx   = 1'b1;
               end else begin
                  buf_ir_nx    = mem1_rdata;
                  buf_valid_nx = 1'b1;
                  state_nx     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_nx        = pc_align(redirect_pc);
               valid_nx     = 1'b0;
               buf_valid_nx = 1'b0;
               state_nx     = ST_FETCH;
            end else if (!stall && buf_valid) begin
               // pc was already stepped past the buffered word on capture.
               ir_nx        = buf_ir;
               ifid_pc_nx   = pc;
               valid_nx     = 1'b1;
               buf_valid_nx = 1'b0;
               state_nx     = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (redirect) begin
               pc_nx        = pc_align(redirect_pc);
               valid_nx     = 1'b0;
               buf_valid_nx = 1'b0;
            end else if (resp_ok) begin
               state_nx = ST_FETCH;
            end
         end
         default: begin
            state_nx     = ST_FETCH;
            valid_nx     = 1'b0;
            buf_valid_nx = 1'b0;
         end
      endcase
   end

   // State, PC, buffer and IF/ID register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_FETCH;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         buf_ir     <= '0;
         buf_valid  <= 1'b0;
         ifid_ir    <= '0;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         req_addr   <= req_addr_nx;
         buf_ir     <= buf_ir_nx;
         buf_valid  <= buf_valid_nx;
         ifid_ir    <= ir_nx;
         ifid_pc    <= ifid_pc_nx;
         ifid_valid <= valid_nx;
      end
   end

   // Memory request: address frozen at the pre-redirect value in DISCARD.
   always_comb begin
      mem1_read    = req_en & (state != ST_HOLD);
      mem1_address = (state == ST_DISCARD) ? req_addr : pc;
   end

   assign opcode = ifid_ir[15:12];
   assign IRbits = ifid_ir[11:0];

`ifdef FETCH_PERF_EN
   logic fetched_inc;

   // A new word lands in IF/ID whenever valid is set without a hold.
   assign fetched_inc = valid_nx & ~hold_ifid;

   fetch_perf_ctr u_perf (
      .clk          (clk),
      .reset_n      (reset_n),
      .fetched_inc  (fetched_inc),
      .stall_inc    (hold_ifid),
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
   import lc3b_types::*;

   logic        clk;
   logic        reset_n;
   logic        mem1_read;
   logic [15:0] mem1_address;
   logic        mem1_resp;
   logic [15:0] mem1_rdata;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        ifid_valid;
   logic [15:0] ifid_ir;
   logic [15:0] ifid_pc;
   logic [3:0]  opcode;
   logic [11:0] IRbits;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched;
   logic [15:0] perf_stall;
`endif

   int n_total = 0;
   int n_bad   = 0;

   fetch_stage #(.RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem1_read    (mem1_read),
      .mem1_address (mem1_address),
      .mem1_resp    (mem1_resp),
      .mem1_rdata   (mem1_rdata),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .ifid_valid   (ifid_valid),
      .ifid_ir      (ifid_ir),
      .ifid_pc      (ifid_pc),
      .opcode       (opcode),
`ifdef FETCH_PERF_EN
      .IRbits       (IRbits),
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`else
      .IRbits       (IRbits)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Starts at a negedge with the request for addr visible; response comes
   // one cycle later and the IF/ID contents are checked after the capture.
   task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data);
      logic [15:0] nxt;
      nxt = addr + 16'd2;
      check_val("req_read", 16'(mem1_read), 16'd1);
      check_val("req_addr", mem1_address, addr);
      @(negedge clk);
      check_val("addr_stable", mem1_address, addr);
      mem1_resp  = 1'b1;
      mem1_rdata = data;
      @(negedge clk);
      mem1_resp = 1'b0;
      check_val("ifid_valid", 16'(ifid_valid), 16'd1);
      check_val("ifid_ir", ifid_ir, data);
      check_val("ifid_pc", ifid_pc, nxt);
      check_val("opcode", 16'(opcode), 16'(data[15:12]));
      check_val("irbits", 16'(IRbits), 16'(data[11:0]));
      check_val("next_addr", mem1_address, nxt);
   endtask

   initial begin
      reset_n     = 1'b0;
      mem1_resp   = 1'b0;
      mem1_rdata  = 16'h0000;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;

      @(negedge clk);
      @(negedge clk);
      check_val("rst_read", 16'(mem1_read), 16'd0);
      check_val("rst_valid", 16'(ifid_valid), 16'd0);
      check_val("rst_ir", ifid_ir, 16'h0000);
      check_val("rst_pc", ifid_pc, 16'h0000);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("first_read", 16'(mem1_read), 16'd1);
      check_val("first_addr", mem1_address, 16'h0000);

      do_fetch(16'h0000, 16'h1000);
      do_fetch(16'h0002, 16'h1001);
      do_fetch(16'h0004, 16'h1002);

      // Stall with a live entry: response goes to the buffer (HOLD).
      stall = 1'b1;
      @(negedge clk);
      check_val("stall_hold_valid", 16'(ifid_valid), 16'd1);
      check_val("stall_hold_ir", ifid_ir, 16'h1002);
      mem1_resp  = 1'b1;
      mem1_rdata = 16'h1234;
      @(negedge clk);
      mem1_resp = 1'b0;
      check_val("hold_state", 16'(dut.state), 16'(ST_HOLD));
      check_val("hold_read", 16'(mem1_read), 16'd0);
      check_val("hold_ir", ifid_ir, 16'h1002);
      check_val("hold_pc", ifid_pc, 16'h0006);
      stall = 1'b0;
      @(negedge clk);
      check_val("drain_ir", ifid_ir, 16'h1234);
      check_val("drain_pc", ifid_pc, 16'h0008);
      check_val("drain_valid", 16'(ifid_valid), 16'd1);
      check_val("drain_state", 16'(dut.state), 16'(ST_FETCH));
      check_val("drain_addr", mem1_address, 16'h0008);

      // Redirect together with stall and live entry.
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0100;
      @(negedge clk);
      redirect = 1'b0;
      stall    = 1'b0;
      check_val("rs_valid", 16'(ifid_valid), 16'd0);
      check_val("rs_state", 16'(dut.state), 16'(ST_DISCARD));
      check_val("rs_addr", mem1_address, 16'h0008);
      mem1_resp  = 1'b1;
      mem1_rdata = 16'hdead;
      @(negedge clk);
      mem1_resp = 1'b0;
      check_val("rs_drop_state", 16'(dut.state), 16'(ST_FETCH));
      check_val("rs_drop_valid", 16'(ifid_valid), 16'd0);
      check_val("rs_drop_addr", mem1_address, 16'h0100);
      do_fetch(16'h0100, 16'h2000);

      // Redirect to an odd target while the request is pending.
      redirect    = 1'b1;
      redirect_pc = 16'h0041;
      @(negedge clk);
      redirect = 1'b0;
      check_val("disc_state", 16'(dut.state), 16'(ST_DISCARD));
      check_val("disc_read", 16'(mem1_read), 16'd1);
      check_val("disc_addr", mem1_address, 16'h0102);
      check_val("disc_valid", 16'(ifid_valid), 16'd0);
      @(negedge clk);
      check_val("disc_addr_stable", mem1_address, 16'h0102);
      mem1_resp  = 1'b1;
      mem1_rdata = 16'hbeef;
      @(negedge clk);
      mem1_resp = 1'b0;
      check_val("late_valid", 16'(ifid_valid), 16'd0);
      check_val("late_ir", ifid_ir, 16'h2000);
      check_val("late_addr", mem1_address, 16'h0040);
      check_val("late_state", 16'(dut.state), 16'(ST_FETCH));

      // Redirect with response in the same cycle: data dropped, stay FETCH.
      redirect    = 1'b1;
      redirect_pc = 16'hfffe;
      mem1_resp   = 1'b1;
      mem1_rdata  = 16'h5555;
      @(negedge clk);
      redirect  = 1'b0;
      mem1_resp = 1'b0;
      check_val("rr_state", 16'(dut.state), 16'(ST_FETCH));
      check_val("rr_valid", 16'(ifid_valid), 16'd0);
      check_val("rr_addr", mem1_address, 16'hfffe);
      do_fetch(16'hfffe, 16'h7abc);

      // Redirect out of HOLD.
      stall      = 1'b1;
      mem1_resp  = 1'b1;
      mem1_rdata = 16'h1111;
      @(negedge clk);
      mem1_resp = 1'b0;
      check_val("h2_state", 16'(dut.state), 16'(ST_HOLD));
      check_val("h2_read", 16'(mem1_read), 16'd0);
      redirect    = 1'b1;
      redirect_pc = 16'h0300;
      @(negedge clk);
      redirect = 1'b0;
      stall    = 1'b0;
      check_val("hr_state", 16'(dut.state), 16'(ST_FETCH));
      check_val("hr_valid", 16'(ifid_valid), 16'd0);
      check_val("hr_read", 16'(mem1_read), 16'd1);
      check_val("hr_addr", mem1_address, 16'h0300);

      // Reset pulsed mid-request, between clock edges.
      #2;
      reset_n = 1'b0;
      #1;
      check_val("mr_read", 16'(mem1_read), 16'd0);
      check_val("mr_valid", 16'(ifid_valid), 16'd0);
      check_val("mr_ir", ifid_ir, 16'h0000);
      check_val("mr_state", 16'(dut.state), 16'(ST_FETCH));
      @(negedge clk);
      check_val("mr_read_held", 16'(mem1_read), 16'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("mr_restart_read", 16'(mem1_read), 16'd1);
      check_val("mr_restart_addr", mem1_address, 16'h0000);
      do_fetch(16'h0000, 16'h3abc);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
